// File: rtl/demux_registrado.sv
// 1-to-N valid/ready demultiplexer with a one-entry output register per channel.
// Beats whose controle has no channel are accepted, dropped, and flagged on erro.
//
// Each channel's valid bit is a 2-state flag:
//   state | meaning
//   VAZIO | saida_valida[i] = 0, channel register holds no beat
//   CHEIO | saida_valida[i] = 1, channel register holds a beat for consumer i
module demux_registrado #(
  parameter int LARGURA  = 32,
  parameter int N_SAIDAS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [LARGURA-1:0]          entrada,
  input  logic [SEL_W-1:0]            controle,
  input  logic                        entrada_valida,
  output logic                        entrada_pronta,
  output logic [N_SAIDAS*LARGURA-1:0] saida,
  output logic [N_SAIDAS-1:0]         saida_valida,
  input  logic [N_SAIDAS-1:0]         saida_pronta,
  output logic                        erro
);

  logic [N_SAIDAS-1:0] sel_dec;
  logic [N_SAIDAS-1:0] carga;
  logic                legal;
  logic                ocupado;
  logic                disparo;

  // One-hot decode of controle; all zeros when controle names no channel.
  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < N_SAIDAS; i++) begin
      if (controle == SEL_W'(i)) sel_dec[i] = 1'b1;
    end
  end

  assign legal   = |sel_dec;
  // Only the selected channel can stall the producer, and only while it is
  // full and its consumer is not draining it this cycle.
  assign ocupado = |(sel_dec & saida_valida & ~saida_pronta);

  assign entrada_pronta = !reset && !ocupado;
  assign disparo        = entrada_valida && entrada_pronta;
  assign carga          = sel_dec & {N_SAIDAS{disparo}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida        <= '0;
      saida_valida <= '0;
      erro         <= 1'b0;
    end else begin
      erro <= disparo && !legal;
      for (int i = 0; i < N_SAIDAS; i++) begin
        if (carga[i]) begin
          saida[i*LARGURA +: LARGURA] <= entrada;
          saida_valida[i]             <= 1'b1;
        end else if (saida_pronta[i]) begin
          saida_valida[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_registrado.sv
// Bench for demux_registrado: directed cases plus random traffic checked
// against per-channel expected-data queues.
module tb_demux_registrado;

  localparam int L = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [L-1:0]  entrada;
  logic [1:0]    controle;
  logic          entrada_valida;
  logic          entrada_pronta;
  logic [4*L-1:0] saida;
  logic [3:0]    saida_valida;
  logic [3:0]    saida_pronta;
  logic          erro;

  logic [L-1:0]  entrada3;
  logic [1:0]    controle3;
  logic          entrada_valida3;
  logic          entrada_pronta3;
  logic [3*L-1:0] saida3;
  logic [2:0]    saida_valida3;
  logic [2:0]    saida_pronta3;
  logic          erro3;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_on = 1'b0;
  bit err_exp = 1'b0;
  logic [L-1:0] fila [4][$];

  demux_registrado #(.LARGURA(L), .N_SAIDAS(4), .SEL_W(2)) dut (
    .clock(clock), .reset(reset), .entrada(entrada), .controle(controle),
    .entrada_valida(entrada_valida), .entrada_pronta(entrada_pronta),
    .saida(saida), .saida_valida(saida_valida), .saida_pronta(saida_pronta),
    .erro(erro)
  );

  demux_registrado #(.LARGURA(L), .N_SAIDAS(3), .SEL_W(2)) dut3 (
    .clock(clock), .reset(reset), .entrada(entrada3), .controle(controle3),
    .entrada_valida(entrada_valida3), .entrada_pronta(entrada_pronta3),
    .saida(saida3), .saida_valida(saida_valida3), .saida_pronta(saida_pronta3),
    .erro(erro3)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ctl, input logic [L-1:0] d);
    entrada_valida = v;
    controle       = ctl;
    entrada        = d;
  endtask

  // Scoreboard: compares held data/valid against the queues, predicts ready,
  // then retires drained beats and records beats that will be accepted.
  always @(negedge clock) begin
    if (mon_on && !reset) begin
      logic exp_pr;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("sb_valid%0d", i), 64'(saida_valida[i]), 64'(fila[i].size() != 0));
        if (fila[i].size() != 0)
          check($sformatf("sb_data%0d", i), 64'(saida[i*L +: L]), 64'(fila[i][0]));
      end
      exp_pr = !((fila[controle].size() != 0) && !saida_pronta[controle]);
      check("sb_pronta", 64'(entrada_pronta), 64'(exp_pr));
      check("sb_erro", 64'(erro), 64'(err_exp));
      err_exp = 1'b0;
      for (int i = 0; i < 4; i++)
        if (fila[i].size() != 0 && saida_pronta[i]) void'(fila[i].pop_front());
      if (entrada_valida && exp_pr) fila[controle].push_back(entrada);
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'd0, '0);
    saida_pronta    = 4'b1111;
    entrada3        = '0;
    controle3       = 2'd0;
    entrada_valida3 = 1'b0;
    saida_pronta3   = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 64'(saida_valida), 64'h0);
    check("rst_saida", 64'(|saida), 64'h0);
    check("rst_erro", 64'(erro), 64'h0);
    check("rst_pronta_low", 64'(entrada_pronta), 64'h0);
    reset = 1'b0;
    #1;
    check("rst_pronta_high", 64'(entrada_pronta), 64'h1);
    mon_on = 1'b1;

    // single beat to channel 2
    drive(1'b1, 2'd2, 32'hA5A5_0001);
    step();
    drive(1'b0, 2'd0, '0);
    check("t1_valid", 64'(saida_valida), 64'h4);
    check("t1_data", 64'(saida[2*L +: L]), 64'hA5A5_0001);
    step();
    check("t1_drain", 64'(saida_valida), 64'h0);

    // stalled channel 1 blocks only itself
    saida_pronta = 4'b1101;
    drive(1'b1, 2'd1, 32'h11);
    step();
    check("t2_valid1", 64'(saida_valida), 64'h2);
    drive(1'b1, 2'd1, 32'h99);
    #1;
    check("t2_blocked", 64'(entrada_pronta), 64'h0);
    drive(1'b1, 2'd3, 32'h33);
    saida_pronta = 4'b0101;
    #1;
    check("t2_other_ok", 64'(entrada_pronta), 64'h1);
    step();
    drive(1'b0, 2'd0, '0);
    check("t2_valid13", 64'(saida_valida), 64'ha);
    check("t2_hold1", 64'(saida[1*L +: L]), 64'h11);
    check("t2_data3", 64'(saida[3*L +: L]), 64'h33);
    saida_pronta = 4'b1111;
    step();
    check("t2_drain", 64'(saida_valida), 64'h0);

    // back-to-back on channel 0
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 2'd0, 32'(k));
      #1;
      check("t3_pronta", 64'(entrada_pronta), 64'h1);
      step();
      check("t3_data", 64'(saida[0 +: L]), 64'(k));
      check("t3_valid", 64'(saida_valida), 64'h1);
    end
    drive(1'b0, 2'd0, '0);
    step();
    check("t3_drain", 64'(saida_valida), 64'h0);

    // illegal destination on the 3-channel instance
    controle3 = 2'd1; entrada3 = 32'h5151; entrada_valida3 = 1'b1;
    step();
    check("t4_load1", 64'(saida_valida3), 64'h2);
    check("t4_no_erro", 64'(erro3), 64'h0);
    controle3 = 2'd3; entrada3 = 32'hDEAD;
    #1;
    check("t4_pronta", 64'(entrada_pronta3), 64'h1);
    step();
    entrada_valida3 = 1'b0;
    check("t4_erro", 64'(erro3), 64'h1);
    check("t4_valid_same", 64'(saida_valida3), 64'h2);
    check("t4_data_same", 64'(saida3[1*L +: L]), 64'h5151);
    step();
    check("t4_erro_pulse", 64'(erro3), 64'h0);

    // reset in the middle of traffic
    saida_pronta = 4'b0000;
    drive(1'b1, 2'd0, 32'hC0);
    step();
    drive(1'b1, 2'd2, 32'hC2);
    step();
    drive(1'b0, 2'd0, '0);
    check("t5_filled", 64'(saida_valida), 64'h5);
    reset = 1'b1;
    #1;
    check("t5_valid_clr", 64'(saida_valida), 64'h0);
    check("t5_erro", 64'(erro), 64'h0);
    check("t5_pronta_low", 64'(entrada_pronta), 64'h0);
    check("t5_valid3_clr", 64'(saida_valida3), 64'h0);
    for (int i = 0; i < 4; i++) fila[i].delete();
    err_exp = 1'b0;
    #1;
    reset = 1'b0;
    step();
    saida_pronta = 4'b1111;
    drive(1'b1, 2'd2, 32'h77);
    step();
    drive(1'b0, 2'd0, '0);
    check("t5_resume_valid", 64'(saida_valida), 64'h4);
    check("t5_resume_data", 64'(saida[2*L +: L]), 64'h77);
    step();

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      saida_pronta = 4'($urandom);
      step();
    end
    drive(1'b0, 2'd0, '0);
    saida_pronta = 4'b1111;
    repeat (3) step();
    for (int i = 0; i < 4; i++)
      check($sformatf("end_empty%0d", i), 64'(fila[i].size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_registrado.md
Name: demux_registrado

Overview:
- 1-to-N demultiplexer with valid/ready stream handshake. It is the counterpart of the processor's N-to-1 multiplexers: one producer stream is steered to one of N consumer channels by a select field.
- Each output channel owns a one-entry output register. A stalled channel therefore never blocks transfers to other channels.
- Used in the single-cycle datapath wherever a result must be routed to one of several registered destinations (write-back / peripheral steering).

Parameters:
- LARGURA, 32, data width in bits of the input and of each output channel.
- N_SAIDAS, 4, number of output channels (2..2**SEL_W).
- SEL_W, 2, width of the select input.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- entrada  input  LARGURA  input data.
- controle  input  SEL_W  destination channel index, sampled with entrada.
- entrada_valida  input  1  producer asserts when entrada/controle are valid.
- entrada_pronta  output  1  block can accept the current beat.
- saida  output  N_SAIDAS*LARGURA  channel i data occupies bits [i*LARGURA +: LARGURA].
- saida_valida  output  N_SAIDAS  bit i set when channel i register holds a beat.
- saida_pronta  input  N_SAIDAS  bit i set when consumer i accepts.
- erro  output  1  one-cycle pulse when a beat with an illegal controle is accepted and discarded.

Behaviour:
- Reset (async, active-high, immediate):
  - saida_valida = 0, saida = 0, erro = 0.
  - entrada_pronta = 1 once reset deasserts; it is forced to 0 while reset is high.
- Definitions:
  - Input fire: entrada_valida && entrada_pronta at a rising edge.
  - Output fire on i: saida_valida[i] && saida_pronta[i].
- entrada_pronta is combinational:
  - If controle < N_SAIDAS: entrada_pronta = !saida_valida[controle] || saida_pronta[controle] (pass-through drain allowed).
  - If controle >= N_SAIDAS: entrada_pronta = 1.
- Input fire with legal controle = k:
  - Channel k data register loads entrada; saida_valida[k] is 1 next cycle.
  - Latency from input fire to saida_valida is 1 cycle.
  - No other channel changes.
- Input fire with controle >= N_SAIDAS:
  - Beat is discarded; no channel changes.
  - erro = 1 for exactly the next cycle, then 0 unless another illegal beat fires.
- Output fire on i without a simultaneous load to i: saida_valida[i] clears next cycle. saida[i] holds its last value; data is not cleared.
- Output fire on i and load to i in the same cycle: saida_valida[i] stays 1 and saida[i] takes the new data, giving full throughput of 1 beat/cycle per channel.
- Stable outputs: while saida_valida[i] = 1 and saida_pronta[i] = 0, saida[i] and saida_valida[i] must not change.
- Independence: channels drain independently; several saida_valida bits may be 1 at once. At most one channel loads per cycle.
- Zero-latency paths: no combinational path from entrada to saida. The only combinational paths are from saida_pronta and controle to entrada_pronta.
- No internal FSM beyond the per-channel valid flags; valid flag i is a 2-state machine:
  - VAZIO -> CHEIO on a load to i.
  - CHEIO -> VAZIO on output fire on i without a load.
  - CHEIO -> CHEIO on load+fire or on stall.
- Reset mid-operation: all held beats are lost, saida_valida returns to 0 asynchronously, and no erro pulse is generated.

Test Plan:
- Reset, then send entrada=0xA5A5_0001, controle=2, saida_pronta=4'b1111 -> next cycle saida_valida=4'b0100 and saida[2]=0xA5A5_0001; the cycle after, saida_valida=0.
- Stall channel 1 (saida_pronta[1]=0) holding 0x11, then send controle=1 -> entrada_pronta=0. Then send controle=3 data 0x33 -> accepted; saida_valida=4'b1010 with saida[1]=0x11 unchanged.
- Back-to-back on channel 0: beats 1,2,3,4 on consecutive cycles with saida_pronta[0]=1 -> entrada_pronta stays 1 and saida[0] shows 1,2,3,4 on consecutive cycles with no bubbles.
- N_SAIDAS=3, controle=3 with entrada_valida=1 -> entrada_pronta=1, erro=1 for one cycle, saida_valida unchanged.
- Fill channels 0 and 2, then assert reset for half a cycle mid-stream -> saida_valida=0 immediately, erro=0, and normal operation resumes after release.
- Random traffic over 10k cycles with random saida_pronta -> a scoreboard confirms per-channel in-order delivery, no loss or duplication of legal beats, and output stability under stall.
